// File: rtl/product_bcd_pkg.sv
// Shared types and constants for the product-to-BCD converter.
//   state_t     : converter FSM states (IDLE, SHIFT, DONE)
//   bcd_digit_t : one packed BCD digit
//   BCD_ADJUST_THRESH / BCD_ADJUST_ADD : double-dabble add-3 rule
package product_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADJUST_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADJUST_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational double-dabble digit correction.
//   i_digit : current BCD digit
//   o_digit : i_digit + 3 when i_digit >= 5, otherwise i_digit
module bcd_digit_adjust
  import product_bcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_ADJUST_THRESH) o_digit = i_digit + BCD_ADJUST_ADD;
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential signed-product to sign + BCD magnitude converter (double-dabble,
// one shift per clock). Downstream of the 8-bit signed shift-add multiplier.
// Optional macro PRODUCT_BCD_BLANK_EN: blank leading-zero digits via DigitEn.
// Ports:
//   Clk, Reset      : clock, async active-high reset
//   Start           : conversion request, sampled only in IDLE
//   Ahi, Blo        : upper/lower halves of the two's-complement product
//   Busy            : conversion in progress (state != IDLE)
//   Done            : one-cycle pulse when Bcd/Neg/DigitEn update
//   Neg, Bcd        : sign and magnitude digits (digit 0 in Bcd[3:0])
//   DigitEn         : per-digit display enable
module product_bcd_converter
  import product_bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH/2-1:0]    Ahi,
  input  logic [WIDTH/2-1:0]    Blo,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Neg,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic [DIGITS-1:0]     DigitEn
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [WIDTH-1:0]    r_mag;
  logic [4*DIGITS-1:0] r_acc;
  logic                r_sign;
  logic [CW-1:0]       r_cnt;
  logic                r_done;
  logic                r_neg;
  logic [4*DIGITS-1:0] r_bcd;

  logic [WIDTH-1:0]    w_prod;
  logic [WIDTH-1:0]    w_mag_in;
  logic [4*DIGITS-1:0] w_adj;

  assign w_prod   = {Ahi, Blo};
  // Negation wraps -2^(WIDTH-1) onto itself, which read unsigned is the
  // correct magnitude.
  assign w_mag_in = w_prod[WIDTH-1] ? (~w_prod + ONE) : w_prod;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

`ifdef PRODUCT_BCD_BLANK_EN
  logic [DIGITS-1:0] r_en;
  logic [DIGITS-1:0] w_en;

  // Enable every digit at or below the most significant nonzero digit.
  always_comb begin
    logic v_seen;
    v_seen = 1'b0;
    w_en   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_seen  = v_seen | (|r_acc[4*i +: 4]);
      w_en[i] = v_seen;
    end
    w_en[0] = 1'b1;
  end

  assign DigitEn = r_en;
`else
  assign DigitEn = '1;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_mag   <= '0;
      r_acc   <= '0;
      r_sign  <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_neg   <= 1'b0;
      r_bcd   <= '0;
`ifdef PRODUCT_BCD_BLANK_EN
      r_en    <= '1;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (Start) begin
          r_sign  <= w_prod[WIDTH-1];
          r_mag   <= w_mag_in;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_acc <= {w_adj[4*DIGITS-2:0], r_mag[WIDTH-1]};
          r_mag <= {r_mag[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CONE;
          if (r_cnt == LAST) r_state <= DONE;
        end
        DONE: begin
          r_bcd   <= r_acc;
          r_neg   <= r_sign;
`ifdef PRODUCT_BCD_BLANK_EN
          r_en    <= w_en;
`endif
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Busy = (r_state != IDLE);
  assign Done = r_done;
  assign Neg  = r_neg;
  assign Bcd  = r_bcd;

endmodule

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
- Downstream stage of the 8-bit signed shift-add multiplier.
- Consumes the 16-bit two's-complement product (upper byte from the A register, lower byte from the B register) on a start pulse.
- Converts it sequentially (double-dabble, one shift per clock) to sign plus magnitude BCD digits for the decimal display driver.

Parameters:
- WIDTH, 16, product width in bits; must be even. Upper half is Ahi, lower half is Blo.
- DIGITS, 5, BCD digits produced; must satisfy 10^DIGITS > 2^(WIDTH-1).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request a conversion; sampled only in IDLE.
- Ahi  input  WIDTH/2  upper half of the product (multiplier A register).
- Blo  input  WIDTH/2  lower half of the product (multiplier B register).
- Busy  output  1  high while a conversion is in progress (state != IDLE).
- Done  output  1  one-cycle pulse when Bcd/Neg/DigitEn are updated.
- Neg  output  1  sign of the last converted product (1 = negative).
- Bcd  output  4*DIGITS  magnitude digits; digit 0 in bits [3:0].
- DigitEn  output  DIGITS  per-digit display enable (see Optional Feature).

Behaviour:
- Reset (async, active-high):
  - state=IDLE; Busy=0, Done=0, Neg=0, Bcd=0, DigitEn=all ones.
  - Internal shift register and counter cleared.
  - Reset mid-conversion aborts it; no Done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with Start=1, capture P={Ahi,Blo}.
  - Set sign=P[WIDTH-1] and mag=|P| as a WIDTH-bit unsigned value; -2^(WIDTH-1) yields magnitude 2^(WIDTH-1) with no overflow.
  - Clear the digit accumulator, set count=0, go to SHIFT.
- SHIFT, each edge:
  - Every digit >=5 has 3 added (add-3 adjust on the current accumulator).
  - Then {digits,mag} shifts left 1 and count increments.
  - After WIDTH shifts (count==WIDTH-1 at the edge), go to DONE.
- DONE, one edge:
  - Load the Bcd, Neg and DigitEn output registers.
  - Done=1 for the following cycle; go to IDLE.
- Latency: Start sampled at edge 0; Done high in the cycle after edge WIDTH+1 (17 for the default).
  - Busy is high from edge 0 until the edge that raises Done.
  - Done and Busy are never both high.
- Outputs hold their last converted value until the next DONE or Reset. Inputs may change freely after the Start edge.
- Start while Busy=1, including in DONE, is ignored and not queued. A Start held high re-triggers in the first IDLE cycle after Done.
- Zero product: Neg=0 (never negative zero).
- Ahi/Blo are sampled only at the Start edge.

Optional Feature:
- Macro: PRODUCT_BCD_BLANK_EN.
- Defined:
  - DigitEn[i]=0 for leading-zero digits above the most significant nonzero digit.
  - Digit 0 is always enabled, so a zero value gives DigitEn=5'b00001.
  - Computed in DONE together with Bcd.
- Undefined: DigitEn is constant all ones; no blanking logic is synthesized.

Decomposition:
- Package product_bcd_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - typedef bcd_digit_t (logic [3:0]);
  - constant BCD_ADJUST_THRESH=5 and BCD_ADJUST_ADD=3.
- Sub-module bcd_digit_adjust (purely combinational): takes a bcd_digit_t and returns digit+3 when >=5, else the digit unchanged. It is instantiated DIGITS times inside a generate loop.

Test Plan:
- Ahi=0xFE, Blo=0x63 (-59*7 = -413), Start 1 cycle -> Done exactly 17 cycles later; Neg=1, Bcd=0x00413; DigitEn=5'b00111 with blanking, 5'b11111 without.
- Ahi=0x7F, Blo=0xFF -> Neg=0, Bcd=0x32767, DigitEn=5'b11111.
- Ahi=0x80, Blo=0x00 -> Neg=1, Bcd=0x32768 (most-negative boundary).
- Ahi=0x00, Blo=0x00 -> Neg=0, Bcd=0x00000, DigitEn=5'b00001 with blanking; then Ahi=0xFF, Blo=0xFF -> Neg=1, Bcd=0x00001.
- Start at 0x0007, then Start with 0x1234 pulsed 5 cycles later while Busy -> a single Done; Bcd=0x00007; the second request is not queued.
- Start at 0xFE63, Reset pulsed at cycle 8 -> outputs return to reset values immediately, no Done; a fresh Start afterwards converts normally.
